// File: rtl/add_sched8.sv
// Two-requester round-robin front end for a single shared 8-bit carry-lookahead adder.
// 8-bit adds take one adder pass, 16-bit adds take two with the carry chained between bytes.

module cla8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       ci_i,
    output logic [7:0] s_o,
    output logic       co_o
);

    // Each carry is a flat sum of generate terms gated by the propagates below it.
    function automatic logic [8:0] cla_carry(input logic [7:0] g, input logic [7:0] p, input logic c0);
        logic [8:0] c;
        logic       pp;
        c[0] = c0;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & c0);
        end
        return c;
    endfunction

    logic [7:0] gen_s;
    logic [7:0] prop_s;
    logic [8:0] carry_s;

    // Generate/propagate terms, lookahead carries and the sum.
    always_comb begin
        gen_s   = a_i & b_i;
        prop_s  = a_i ^ b_i;
        carry_s = cla_carry(gen_s, prop_s, ci_i);
        s_o     = prop_s ^ carry_s[7:0];
        co_o    = carry_s[8];
    end

endmodule

module add_sched8 (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        w16_0,
    input  logic        w16_1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    input  logic        ci0,
    input  logic        ci1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] s,
    output logic        co,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        prio_q, prio_d;
    logic        win_q, win_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        ci_q, ci_d;
    logic        w16_q, w16_d;
    logic        carry_q, carry_d;
    logic [15:0] s_q, s_d;
    logic        co_q, co_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        busy_q, busy_d;

    logic        pick_s;
    logic [7:0]  add_a_s;
    logic [7:0]  add_b_s;
    logic        add_ci_s;
    logic [7:0]  add_s_s;
    logic        add_co_s;

    cla8 u_cla8 (
        .a_i  (add_a_s),
        .b_i  (add_b_s),
        .ci_i (add_ci_s),
        .s_o  (add_s_s),
        .co_o (add_co_s)
    );

    // Adder operand mux: low bytes with the captured carry-in, high bytes with the chained carry.
    always_comb begin
        add_a_s  = a_q[7:0];
        add_b_s  = b_q[7:0];
        add_ci_s = ci_q;
        case (state_q)
            ST_HI: begin
                add_a_s  = a_q[15:8];
                add_b_s  = b_q[15:8];
                add_ci_s = carry_q;
            end
            default: begin
                add_a_s  = a_q[7:0];
                add_b_s  = b_q[7:0];
                add_ci_s = ci_q;
            end
        endcase
    end

    // Arbitration, operand capture and pass sequencing.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        win_d   = win_q;
        a_d     = a_q;
        b_d     = b_q;
        ci_d    = ci_q;
        w16_d   = w16_q;
        carry_d = carry_q;
        s_d     = s_q;
        co_d    = co_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        pick_s  = (req0 && req1) ? prio_q : req1;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    win_d   = pick_s;
                    a_d     = pick_s ? a1 : a0;
                    b_d     = pick_s ? b1 : b0;
                    ci_d    = pick_s ? ci1 : ci0;
                    w16_d   = pick_s ? w16_1 : w16_0;
                    gnt0_d  = ~pick_s;
                    gnt1_d  = pick_s;
                    state_d = ST_LO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LO: begin
                s_d[7:0] = add_s_s;
                carry_d  = add_co_s;
                if (w16_q) begin
                    state_d = ST_HI;
                end else begin
                    s_d[15:8] = 8'h00;
                    co_d      = add_co_s;
                    done0_d   = ~win_q;
                    done1_d   = win_q;
                    state_d   = ST_DONE;
                end
            end
            ST_HI: begin
                s_d[15:8] = add_s_s;
                co_d      = add_co_s;
                done0_d   = ~win_q;
                done1_d   = win_q;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                prio_d  = ~win_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            win_q   <= 1'b0;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            ci_q    <= 1'b0;
            w16_q   <= 1'b0;
            carry_q <= 1'b0;
            s_q     <= 16'h0000;
            co_q    <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            win_q   <= win_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ci_q    <= ci_d;
            w16_q   <= w16_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            co_q    <= co_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign done0 = done0_q;
    assign done1 = done1_q;
    assign s     = s_q;
    assign co    = co_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_add_sched8.sv
// Directed bench for add_sched8: single adds, byte-carry chaining, arbitration and reset abort.

module tb_add_sched8;

    logic        clk;
    logic        reset;
    logic        req0, req1, w16_0, w16_1, ci0, ci1;
    logic [15:0] a0, b0, a1, b1;
    logic        gnt0, gnt1, done0, done1, co, busy;
    logic [15:0] s;

    int checks   = 0;
    int failures = 0;

    add_sched8 dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .w16_0 (w16_0),
        .w16_1 (w16_1),
        .a0    (a0),
        .b0    (b0),
        .a1    (a1),
        .b1    (b1),
        .ci0   (ci0),
        .ci1   (ci1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .done0 (done0),
        .done1 (done1),
        .s     (s),
        .co    (co),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full transaction from IDLE; operands are scrambled right after the grant.
    task automatic txn(input string tag, input logic id, input logic w16,
                       input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic [15:0] es, input logic eco);
        if (id == 1'b0) begin
            req0 = 1'b1; w16_0 = w16; a0 = a; b0 = b; ci0 = ci;
        end else begin
            req1 = 1'b1; w16_1 = w16; a1 = a; b1 = b; ci1 = ci;
        end
        @(negedge clk);
        chk1({tag, ".gnt0"}, gnt0, ~id);
        chk1({tag, ".gnt1"}, gnt1, id);
        chk1({tag, ".busy_lo"}, busy, 1'b1);
        chk1({tag, ".done_in_lo"}, done0 | done1, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        a0 = 16'hA5A5; b0 = 16'h5A5A; a1 = 16'hA5A5; b1 = 16'h5A5A; ci0 = ~ci; ci1 = ~ci;
        if (w16) begin
            @(negedge clk);
            chk1({tag, ".pulse_in_hi"}, gnt0 | gnt1 | done0 | done1, 1'b0);
            chk1({tag, ".busy_hi"}, busy, 1'b1);
        end
        @(negedge clk);
        chk1({tag, ".done0"}, done0, ~id);
        chk1({tag, ".done1"}, done1, id);
        chk1({tag, ".gnt_in_done"}, gnt0 | gnt1, 1'b0);
        chk16({tag, ".s"}, s, es);
        chk1({tag, ".co"}, co, eco);
        @(negedge clk);
        chk1({tag, ".busy_idle"}, busy, 1'b0);
        chk1({tag, ".done_cleared"}, done0 | done1, 1'b0);
        chk16({tag, ".s_hold"}, s, es);
        chk1({tag, ".co_hold"}, co, eco);
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; w16_0 = 1'b0; w16_1 = 1'b0; ci0 = 1'b0; ci1 = 1'b0;
        a0 = 16'h0000; b0 = 16'h0000; a1 = 16'h0000; b1 = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        chk16("rst.s", s, 16'h0000);
        chk1("rst.co", co, 1'b0);
        chk1("rst.busy", busy, 1'b0);
        chk1("rst.pulses", gnt0 | gnt1 | done0 | done1, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk1("idle.busy", busy, 1'b0);

        txn("r0_8a", 1'b0, 1'b0, 16'h00F0, 16'h00FE, 1'b0, 16'h00EE, 1'b1);
        txn("r1_8a", 1'b1, 1'b0, 16'h0060, 16'h009F, 1'b0, 16'h00FF, 1'b0);
        txn("r1_8b", 1'b1, 1'b0, 16'h00E0, 16'h0020, 1'b0, 16'h0000, 1'b1);
        txn("r0_16a", 1'b0, 1'b1, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
        txn("r0_16b", 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        txn("r0_8hi", 1'b0, 1'b0, 16'h12F0, 16'h3410, 1'b1, 16'h0001, 1'b1);

        // Both requesters held from reset: strict alternation starting with 0.
        reset = 1'b1;
        req0 = 1'b1; req1 = 1'b1; w16_0 = 1'b0; w16_1 = 1'b0; ci0 = 1'b0; ci1 = 1'b0;
        a0 = 16'h0006; b0 = 16'h000C; a1 = 16'h0060; b1 = 16'h0040;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk1("rr.gnt0", gnt0, (k % 2) == 0);
            chk1("rr.gnt1", gnt1, (k % 2) == 1);
            @(negedge clk);
            chk1("rr.done0", done0, (k % 2) == 0);
            chk1("rr.done1", done1, (k % 2) == 1);
            chk16("rr.s", s, ((k % 2) == 0) ? 16'h0012 : 16'h00A0);
            chk1("rr.co", co, 1'b0);
            @(negedge clk);
            chk1("rr.busy_idle", busy, 1'b0);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk1("rr.quiet", busy, 1'b0);

        // Leave prio pointing at requester 1, then abort a 16-bit add in its HI cycle.
        txn("pre_abort", 1'b0, 1'b0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);
        req0 = 1'b1; w16_0 = 1'b1; a0 = 16'h1234; b0 = 16'h1111; ci0 = 1'b0;
        @(negedge clk);
        chk1("abort.gnt0", gnt0, 1'b1);
        req0 = 1'b0;
        @(negedge clk);
        chk1("abort.busy_hi", busy, 1'b1);
        chk16("abort.s_lo_pass", s, 16'h0045);
        reset = 1'b1;
        #1;
        chk16("abort.s", s, 16'h0000);
        chk1("abort.co", co, 1'b0);
        chk1("abort.busy", busy, 1'b0);
        chk1("abort.pulses", gnt0 | gnt1 | done0 | done1, 1'b0);
        req0 = 1'b1; req1 = 1'b1; w16_0 = 1'b0; w16_1 = 1'b0;
        a0 = 16'h0001; b0 = 16'h0002; a1 = 16'h0010; b1 = 16'h0020;
        @(negedge clk);
        chk1("abort.no_done", done0 | done1, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk1("abort.prio_gnt0", gnt0, 1'b1);
        chk1("abort.prio_gnt1", gnt1, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk1("abort.done0", done0, 1'b1);
        chk16("abort.s_after", s, 16'h0003);
        @(negedge clk);
        chk1("abort.idle", busy, 1'b0);

        // req1 shows up during requester 0's LO cycle and must wait for IDLE.
        req0 = 1'b1; w16_0 = 1'b0; a0 = 16'h0011; b0 = 16'h0022; ci0 = 1'b0;
        @(negedge clk);
        chk1("late.gnt0", gnt0, 1'b1);
        req0 = 1'b0;
        req1 = 1'b1; w16_1 = 1'b0; a1 = 16'h00AB; b1 = 16'h0011; ci1 = 1'b0;
        @(negedge clk);
        chk1("late.done0", done0, 1'b1);
        chk1("late.gnt1_ignored", gnt1, 1'b0);
        chk16("late.s0", s, 16'h0033);
        chk1("late.busy_done", busy, 1'b1);
        @(negedge clk);
        chk1("late.busy_idle", busy, 1'b0);
        chk1("late.gnt1_idle", gnt1, 1'b0);
        @(negedge clk);
        chk1("late.gnt1", gnt1, 1'b1);
        chk1("late.busy_lo", busy, 1'b1);
        req1 = 1'b0;
        @(negedge clk);
        chk1("late.done1", done1, 1'b1);
        chk16("late.s1", s, 16'h00BC);
        chk1("late.co1", co, 1'b0);
        @(negedge clk);
        chk1("late.end_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
